// File: rtl/ram64_array.sv
// ram64_array: 64-word x 16-bit data memory built from 8 banks of 8 words.
// One synchronous write port and one combinational read port share a single
// address. address[5:3] picks the bank and address[2:0] picks the word inside
// it. An asynchronous active-high reset clears every word.
module ram64_array #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);

    localparam int BANK_W = 3;
    localparam int WORD_W = ADDR_W - BANK_W;
    localparam int NBANK  = 2 ** BANK_W;
    localparam int NWORD  = 2 ** WORD_W;

    logic [BANK_W-1:0] bank_sel;
    logic [WORD_W-1:0] word_sel;
    logic [NBANK-1:0]  bank_we;
    logic [WIDTH-1:0]  bank_rd [NBANK];

    assign bank_sel = address[ADDR_W-1:WORD_W];
    assign word_sel = address[WORD_W-1:0];

    // Bank decode: at most one bank sees a write enable, and only while load is high.
    always_comb begin
        bank_we = '0;
        if (load) begin
            bank_we[bank_sel] = 1'b1;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [WIDTH-1:0] mem_q [NWORD];
        logic [WIDTH-1:0] mem_d [NWORD];

        // Next-state: every word holds, except the addressed word of an enabled bank.
        always_comb begin
            for (int w = 0; w < NWORD; w++) begin
                mem_d[w] = mem_q[w];
            end
            if (bank_we[b]) begin
                mem_d[word_sel] = in;
            end
        end

        // Storage: reset clears the whole bank at once and wins over a same-edge write.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int w = 0; w < NWORD; w++) begin
                    mem_q[w] <= '0;
                end
            end else begin
                for (int w = 0; w < NWORD; w++) begin
                    mem_q[w] <= mem_d[w];
                end
            end
        end

        // Word mux inside the bank; purely combinational so reads have no latency.
        assign bank_rd[b] = mem_q[word_sel];
    end

    // Bank mux selects the final read data from the addressed bank.
    assign out = bank_rd[bank_sel];

endmodule

// File: tb/tb_ram64_array.sv
// tb_ram64_array: drives directed and random traffic into ram64_array and
// compares out against a plain array model of the memory on every cycle,
// plus literal expectations at chosen points.
module tb_ram64_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [5:0]  address;
  logic [15:0] out;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [15:0] model [64];
  bit          model_valid = 1'b0;

  ram64_array dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;
    model_valid = 1'b1;
  endtask

  // model: a write lands on the rising edge unless reset is high
  always @(posedge clk) begin
    if (model_valid && !reset && load) model[address] = in;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // compare process: out must equal the model word at the current address
  always @(negedge clk) begin
    if (model_valid) check($sformatf("cycle addr=%0d", address), out, model[address]);
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [5:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    cycle();
    load    = 1'b0;
  endtask

  task automatic read_lit(input logic [5:0] a, input logic [15:0] exp);
    load    = 1'b0;
    address = a;
    #1;
    check($sformatf("read addr=%0d", a), out, exp);
    cycle();
  endtask

  task automatic mid_read(input logic [5:0] a, input logic [15:0] exp);
    load = 1'b0;
    @(negedge clk);
    #1;
    address = a;
    in      = 16'hDEAD;
    #1;
    check($sformatf("mid addr=%0d", a), out, exp);
  endtask

  logic [5:0]  t2_addr [8] = '{6'd0, 6'd1, 6'd8, 6'd10, 6'd25, 6'd37, 6'd48, 6'd63};
  logic [15:0] t2_data [8] = '{16'h0000, 16'h0001, 16'h2008, 16'h300a,
                               16'h4025, 16'h5037, 16'h6048, 16'h7063};

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    in      = 16'h0000;
    address = 6'd0;
    model_reset();
    #1;
    check("reset held", out, 16'h0000);
    cycle();
    cycle();
    reset = 1'b0;

    // 1: sweep after reset
    for (int a = 0; a < 64; a++) read_lit(6'(a), 16'h0000);

    // 2: directed writes then read back
    for (int i = 0; i < 8; i++) write_word(t2_addr[i], t2_data[i]);
    for (int i = 0; i < 8; i++) read_lit(t2_addr[i], t2_data[i]);
    read_lit(6'd21, 16'h0000);

    // 3: load low, in all ones, sweep addresses
    load = 1'b0;
    in   = 16'hFFFF;
    for (int a = 0; a < 64; a++) begin
      address = 6'(a);
      cycle();
    end
    read_lit(6'd63, 16'h7063);
    read_lit(6'd8,  16'h2008);
    read_lit(6'd21, 16'h0000);

    // 4: overwrite and neighbour isolation
    write_word(6'd5, 16'hAAAA);
    write_word(6'd5, 16'h5555);
    read_lit(6'd5,  16'h5555);
    read_lit(6'd4,  16'h0000);
    read_lit(6'd6,  16'h0000);
    read_lit(6'd13, 16'h0000);

    // 5a: reset mid-cycle with clk low clears immediately
    write_word(6'd40, 16'h1234);
    address = 6'd40;
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async reset", out, 16'h0000);
    cycle();
    reset = 1'b0;
    read_lit(6'd40, 16'h0000);
    read_lit(6'd63, 16'h0000);

    // 5b: reset together with load at an edge drops the write
    write_word(6'd7, 16'hBEEF);
    read_lit(6'd7, 16'hBEEF);
    address = 6'd7;
    in      = 16'hCAFE;
    load    = 1'b1;
    reset   = 1'b1;
    model_reset();
    cycle();
    reset = 1'b0;
    load  = 1'b0;
    read_lit(6'd7, 16'h0000);

    // 6: address changes between edges show up combinationally
    write_word(6'd9,  16'h0909);
    write_word(6'd50, 16'h5050);
    mid_read(6'd9,  16'h0909);
    mid_read(6'd50, 16'h5050);
    mid_read(6'd10, 16'h0000);
    mid_read(6'd9,  16'h0909);
    cycle();

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      load    = 1'($urandom_range(0, 1));
      address = 6'($urandom_range(0, 63));
      in      = 16'($urandom);
      cycle();
    end
    load = 1'b0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
